// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one off-chip line port between icache (p0)
// and dcache (p1); one transaction in flight, single-cycle ack back.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state;
    logic   gnt_p1;
    logic   fav_p1;
    logic   pick_p1;

    always_comb begin
        pick_p1 = p1_enable_i & (fav_p1 | ~p0_enable_i);
    end

    // mem_write/addr/data_o are the transaction latches themselves
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            gnt_p1       <= 1'b0;
            fav_p1       <= 1'b1;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            p0_data_o    <= '0;
            p1_data_o    <= '0;
            p0_ack_o     <= 1'b0;
            p1_ack_o     <= 1'b0;
        end else begin
            p0_ack_o <= 1'b0;
            p1_ack_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (p0_enable_i | p1_enable_i) begin
                        gnt_p1       <= pick_p1;
                        fav_p1       <= ~pick_p1;
                        mem_write_o  <= pick_p1 ? p1_write_i : p0_write_i;
                        mem_addr_o   <= pick_p1 ? p1_addr_i : p0_addr_i;
                        mem_data_o   <= pick_p1 ? p1_data_i : p0_data_i;
                        mem_enable_o <= 1'b1;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        if (gnt_p1) begin
                            p1_data_o <= mem_data_i;
                            p1_ack_o  <= 1'b1;
                        end else begin
                            p0_data_o <= mem_data_i;
                            p0_ack_o  <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
